// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and helpers for the FIFO burst reader: FSM state encoding and timer width.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Bits needed to count from zero up to and including the timeout value.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read side plus output stream of the burst reader, bundled as one interface.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  fifo_rd_ena;
    logic [DATA_WIDTH-1:0] fifo_rd_dat;
    logic                  fifo_rd_empty;
    logic [ADDR_WIDTH:0]   fifo_dat_cnt;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_first;
    logic                  m_last;
    logic [ADDR_WIDTH:0]   m_len;
    logic                  busy;

    modport master (
        output fifo_rd_ena,
        input  fifo_rd_dat, fifo_rd_empty, fifo_dat_cnt,
        output m_valid, m_data, m_first, m_last, m_len, busy,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_ena,
        output fifo_rd_dat, fifo_rd_empty, fifo_dat_cnt,
        input  m_valid, m_data, m_first, m_last, m_len, busy,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader_timer.sv
// burst_timeout_timer: idle-residue timer for the burst reader; built only when
// BURST_TIMEOUT_FLUSH_EN is defined.
`ifdef BURST_TIMEOUT_FLUSH_EN
module burst_timeout_timer
    import fifo_burst_reader_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);
    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [TW-1:0] ONE_C     = TW'(1'b1);

    logic [TW-1:0] r_timer;

    // Count idle cycles, saturating at the timeout so expiry stays asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= {TW{1'b0}};
        end else if (i_clear) begin
            r_timer <= {TW{1'b0}};
        end else if (i_run && (r_timer != TIMEOUT_C)) begin
            r_timer <= r_timer + ONE_C;
        end else begin
            r_timer <= r_timer;
        end
    end

    assign o_expired = (r_timer == TIMEOUT_C);
endmodule
`endif

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops fixed-length bursts from an upstream FWFT FIFO onto a valid/ready stream.
// Define BURST_TIMEOUT_FLUSH_EN to flush a partial burst after TIMEOUT idle cycles.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                rst,
    fifo_burst_reader_if.master bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] ZERO_C      = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C       = CW'(1'b1);
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

    state_t                r_state;
    logic [CW-1:0]         r_words_left;
    logic [CW-1:0]         r_m_len;
    logic                  r_first_pending;
    logic                  r_m_valid;
    logic                  r_m_first;
    logic                  r_m_last;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic                  w_pop;
    logic                  w_start;
    logic [CW-1:0]         w_start_len;

`ifdef BURST_TIMEOUT_FLUSH_EN
    logic w_timer_run;
    logic w_timer_clear;
    logic w_timer_expired;

    assign w_timer_run   = (r_state == S_IDLE) && !bus.fifo_rd_empty &&
                           (bus.fifo_dat_cnt < BURST_LEN_C);
    assign w_timer_clear = (r_state != S_IDLE) || bus.fifo_rd_empty || w_start;

    burst_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_timer_run),
        .i_clear   (w_timer_clear),
        .o_expired (w_timer_expired)
    );
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Pop only inside a burst, with words owed, data present and the output slot free.
    always_comb begin
        w_pop = (r_state == S_BURST) && !bus.fifo_rd_empty &&
                (r_words_left != ZERO_C) && (!r_m_valid || bus.m_ready);
    end

    // Burst start decision in IDLE; a full burst wins over a timeout flush.
    always_comb begin
        w_start     = 1'b0;
        w_start_len = BURST_LEN_C;
        if (r_state == S_IDLE) begin
            if (bus.fifo_dat_cnt >= BURST_LEN_C) begin
                w_start     = 1'b1;
                w_start_len = BURST_LEN_C;
            end
`ifdef BURST_TIMEOUT_FLUSH_EN
            else if (w_timer_expired && !bus.fifo_rd_empty) begin
                w_start     = 1'b1;
                w_start_len = bus.fifo_dat_cnt;
            end
`endif
            else begin
                w_start     = 1'b0;
                w_start_len = BURST_LEN_C;
            end
        end else begin
            w_start     = 1'b0;
            w_start_len = BURST_LEN_C;
        end
    end

    // Burst FSM with the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_words_left    <= ZERO_C;
            r_m_len         <= ZERO_C;
            r_first_pending <= 1'b0;
            r_m_valid       <= 1'b0;
            r_m_first       <= 1'b0;
            r_m_last        <= 1'b0;
            r_busy          <= 1'b0;
            r_m_data        <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state         <= S_BURST;
                        r_m_len         <= w_start_len;
                        r_words_left    <= w_start_len;
                        r_first_pending <= 1'b1;
                        r_busy          <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (w_pop) begin
                        r_m_data        <= bus.fifo_rd_dat;
                        r_m_valid       <= 1'b1;
                        r_m_first       <= r_first_pending;
                        r_m_last        <= (r_words_left == ONE_C);
                        r_words_left    <= r_words_left - ONE_C;
                        r_first_pending <= 1'b0;
                        r_state         <= (r_words_left == ONE_C) ? S_DRAIN : S_BURST;
                    end else if (r_m_valid && bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_first <= 1'b0;
                        r_m_last  <= 1'b0;
                    end else begin
                        r_state <= S_BURST;
                    end
                end
                S_DRAIN: begin
                    // Last word must leave before the FSM can look at the fill count again.
                    if (!r_m_valid || bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_first <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_m_valid <= 1'b0;
                    r_m_first <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_ena = w_pop;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_data      = r_m_data;
    assign bus.m_first     = r_m_first;
    assign bus.m_last      = r_m_last;
    assign bus.m_len       = r_m_len;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural FWFT FIFO upstream.
// Works with BURST_TIMEOUT_FLUSH_EN defined or undefined.
module tb_fifo_burst_reader;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int TO = 8;
    localparam int CW = AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write buffer handed to the FIFO model (stimulus writes head, model reads tail).
    logic [DW-1:0] wr_buf [0:255];
    int            wr_head = 0;
    int            wr_tail = 0;
    logic [DW-1:0] fq [$];

    // Scoreboard: stimulus fills exp_* at exp_wr, monitor consumes at exp_rd.
    logic [DW-1:0] exp_d [0:255];
    logic          exp_f [0:255];
    logic          exp_l [0:255];
    logic [CW-1:0] exp_n [0:255];
    int            exp_wr = 0;
    int            exp_rd = 0;
    int            n_acc  = 0;
    int            n_pop  = 0;
    int            acc_cyc [0:255];

    // Upstream FWFT FIFO model.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                fq.delete();
                wr_tail = wr_head;
                bus.fifo_rd_dat   <= '0;
                bus.fifo_rd_empty <= 1'b1;
                bus.fifo_dat_cnt  <= '0;
            end else begin
                if (bus.fifo_rd_ena && (fq.size() > 0)) void'(fq.pop_front());
                while (wr_tail < wr_head) begin
                    fq.push_back(wr_buf[wr_tail]);
                    wr_tail++;
                end
                bus.fifo_rd_empty <= (fq.size() == 0);
                bus.fifo_dat_cnt  <= CW'(fq.size());
                bus.fifo_rd_dat   <= (fq.size() > 0) ? fq[0] : '0;
            end
        end
    end

    // Monitor: checks every accepted word, held stalls and pop legality.
    initial begin
        logic          held;
        logic [DW-1:0] h_data;
        logic          h_first;
        logic          h_last;
        held = 1'b0;
        h_data = '0;
        h_first = 1'b0;
        h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rd = exp_wr;
                held   = 1'b0;
            end else begin
                if (held) begin
                    total++;
                    if (!bus.m_valid || bus.m_data !== h_data || bus.m_first !== h_first || bus.m_last !== h_last) begin
                        bad++;
                        $display("FAIL stall_hold: got v=%b d=%h f=%b l=%b, want v=1 d=%h f=%b l=%b",
                                 bus.m_valid, bus.m_data, bus.m_first, bus.m_last, h_data, h_first, h_last);
                    end
                end
                if (bus.fifo_rd_ena) begin
                    total++;
                    n_pop++;
                    if (bus.fifo_rd_empty || (bus.m_valid && !bus.m_ready)) begin
                        bad++;
                        $display("FAIL pop_guard: got pop with empty=%b valid=%b ready=%b, want no pop",
                                 bus.fifo_rd_empty, bus.m_valid, bus.m_ready);
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    total++;
                    if (exp_rd >= exp_wr) begin
                        bad++;
                        $display("FAIL unexpected_word: got data=%h first=%b last=%b len=%0d, want no word",
                                 bus.m_data, bus.m_first, bus.m_last, bus.m_len);
                    end else begin
                        if (bus.m_data !== exp_d[exp_rd] || bus.m_first !== exp_f[exp_rd] ||
                            bus.m_last !== exp_l[exp_rd] || bus.m_len !== exp_n[exp_rd]) begin
                            bad++;
                            $display("FAIL word[%0d]: got data=%h first=%b last=%b len=%0d, want data=%h first=%b last=%b len=%0d",
                                     exp_rd, bus.m_data, bus.m_first, bus.m_last, bus.m_len,
                                     exp_d[exp_rd], exp_f[exp_rd], exp_l[exp_rd], exp_n[exp_rd]);
                        end
                        exp_rd++;
                    end
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
                held    = bus.m_valid && !bus.m_ready;
                h_data  = bus.m_data;
                h_first = bus.m_first;
                h_last  = bus.m_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr_buf[wr_head] = d;
        wr_head++;
        tick();
    endtask

    task automatic expect_burst(input logic [DW-1:0] start, input int n, input int len);
        for (int i = 0; i < n; i++) begin
            exp_d[exp_wr] = start + DW'(i);
            exp_f[exp_wr] = (i == 0);
            exp_l[exp_wr] = (i == n - 1);
            exp_n[exp_wr] = CW'(len);
            exp_wr++;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (((exp_rd != exp_wr) || bus.busy) && (k < 300)) begin
            tick();
            k++;
        end
        total++;
        if (k >= 300) begin
            bad++;
            $display("FAIL %s_drain: got %0d words outstanding busy=%b, want 0 and idle",
                     name, exp_wr - exp_rd, bus.busy);
        end
    endtask

    initial begin
        int   base;
        int   bp;
        int   k;
        logic pat [0:6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_first", int'(bus.m_first), 0);
        chk("rst_m_last",  int'(bus.m_last), 0);
        chk("rst_m_len",   int'(bus.m_len), 0);
        chk("rst_m_data",  int'(bus.m_data), 0);
        chk("rst_busy",    int'(bus.busy), 0);
        chk("rst_rd_ena",  int'(bus.fifo_rd_ena), 0);
        rst = 1'b0;
        tick();

        // 1: one full burst at full rate
        base = n_acc;
        bp   = n_pop;
        expect_burst(16'h0001, 4, 4);
        for (int i = 1; i <= 4; i++) write_word(DW'(i));
        wait_done("t1");
        chk("t1_span", acc_cyc[base + 3] - acc_cyc[base], 3);
        chk("t1_pops", n_pop - bp, 4);

        // 2: back-pressure pattern
        bp = n_pop;
        expect_burst(16'h0001, 4, 4);
        for (int i = 1; i <= 4; i++) write_word(DW'(i));
        k = 0;
        while (!bus.m_valid && (k < 50)) begin
            tick();
            k++;
        end
        chk("t2_valid_seen", int'(bus.m_valid), 1);
        for (int i = 0; i < 7; i++) begin
            bus.m_ready = pat[i];
            tick();
        end
        bus.m_ready = 1'b1;
        wait_done("t2");
        chk("t2_pops", n_pop - bp, 4);

        // 3: ten words -> two full bursts and a residue of two
        expect_burst(16'h0301, 4, 4);
        expect_burst(16'h0305, 4, 4);
`ifdef BURST_TIMEOUT_FLUSH_EN
        expect_burst(16'h0309, 2, 2);
`endif
        for (int i = 0; i < 10; i++) write_word(16'h0301 + DW'(i));
        wait_done("t3");
`ifdef BURST_TIMEOUT_FLUSH_EN
        chk("t3_flushed_empty", int'(bus.fifo_rd_empty), 1);
`else
        bp = n_pop;
        repeat (100) tick();
        chk("t3_no_pop",   n_pop - bp, 0);
        chk("t3_idle",     int'(bus.busy), 0);
        chk("t3_residue",  int'(bus.fifo_dat_cnt), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // 4: reset in the middle of a burst
        base = n_acc;
        expect_burst(16'h0401, 4, 4);
        for (int i = 0; i < 4; i++) write_word(16'h0401 + DW'(i));
        k = 0;
        while ((n_acc < base + 2) && (k < 50)) begin
            tick();
            k++;
        end
        chk("t4_two_acc", n_acc - base, 2);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", int'(bus.m_valid), 0);
        chk("t4_rst_rd_ena", int'(bus.fifo_rd_ena), 0);
        chk("t4_rst_busy", int'(bus.busy), 0);
        chk("t4_rst_len", int'(bus.m_len), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t4_idle_after", int'(bus.busy), 0);
        expect_burst(16'h0411, 4, 4);
        for (int i = 0; i < 4; i++) write_word(16'h0411 + DW'(i));
        wait_done("t4");

        // 5: full FIFO -> four back-to-back bursts
        base = n_acc;
        for (int b = 0; b < 4; b++) expect_burst(16'h0501 + DW'(4 * b), 4, 4);
        for (int i = 0; i < 16; i++) begin
            wr_buf[wr_head] = 16'h0501 + DW'(i);
            wr_head++;
        end
        tick();
        wait_done("t5");
        chk("t5_span", acc_cyc[base + 15] - acc_cyc[base], 21);
        chk("t5_empty", int'(bus.fifo_rd_empty), 1);

`ifdef BURST_TIMEOUT_FLUSH_EN
        // 6: fourth word arrives before timeout -> full burst, no partial
        base = n_acc;
        expect_burst(16'h0601, 4, 4);
        for (int i = 0; i < 3; i++) write_word(16'h0601 + DW'(i));
        repeat (2) tick();
        write_word(16'h0604);
        wait_done("t6");
        repeat (20) tick();
        chk("t6_words", n_acc - base, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion by 300000, want finish");
        $fatal(1);
    end
endmodule
